// File: rtl/spike_pkg.sv
// Shared types, FSM encoding, default ramp constants and the saturating adder
// for the letter-to-spike encoder.
package spike_pkg;

    typedef logic [7:0]  letter_t;
    typedef logic [15:0] voltage_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHARGE  = 2'd1,
        FIRE    = 2'd2,
        REFRACT = 2'd3
    } state_t;

    localparam voltage_t RAMP_STEP_DEF = 16'd4096;
    localparam voltage_t THRESHOLD_DEF = 16'hF000;

    // 17-bit add clamped to the 16-bit ceiling so a large step never wraps.
    function automatic voltage_t sat16(input voltage_t a, input voltage_t b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/letter_fifo.sv
// Small synchronous FIFO for queued letters; push is refused when full and
// pop is ignored when empty, pointers carry a wrap bit.
module letter_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign empty     = (r_wr == r_rd);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/letter2spike.sv
// Letter-to-spike encoder: queues letters, ramps voltage per letter, fires one
// spike, then sits out a refractory window. LETTER2SPIKE_DROP_CNT_EN adds drop_count.
module letter2spike
    import spike_pkg::*;
#(
    parameter int       FIFO_DEPTH     = 4,
    parameter voltage_t RAMP_STEP      = RAMP_STEP_DEF,
    parameter voltage_t THRESHOLD      = THRESHOLD_DEF,
    parameter int       REFRACT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  letter_in,
    input  logic        letter_valid,
    output logic        letter_ready,
    output logic [7:0]  neuron_id,
    output logic [15:0] voltage,
    output logic        spike,
    output logic        busy
`ifdef LETTER2SPIKE_DROP_CNT_EN
    ,
    output logic [7:0]  drop_count
`endif
);

    localparam int CW = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = (REFRACT_CYCLES > 0) ? CW'(REFRACT_CYCLES - 1) : '0;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    letter_t       w_head;
    voltage_t      w_vnext;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign letter_ready = !w_full;
    assign w_push       = letter_valid && !w_full;
    // Zero letters are popped too; they just never leave IDLE.
    assign w_pop        = (r_state == IDLE) && !w_empty;
    assign busy         = (r_state != IDLE) || !w_empty;
    assign w_vnext      = sat16(voltage, RAMP_STEP);

    letter_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (letter_in),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            neuron_id <= '0;
            voltage   <= '0;
            spike     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop && w_head != '0) begin
                        neuron_id <= w_head;
                        voltage   <= '0;
                        r_state   <= CHARGE;
                    end
                end
                CHARGE: begin
                    voltage <= w_vnext;
                    if (w_vnext >= THRESHOLD) begin
                        spike   <= 1'b1;
                        r_state <= FIRE;
                    end
                end
                FIRE: begin
                    spike   <= 1'b0;
                    voltage <= '0;
                    if (REFRACT_CYCLES == 0) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= REFRACT;
                        r_cnt   <= CNT_INIT;
                    end
                end
                REFRACT: begin
                    if (r_cnt == '0) r_state <= IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LETTER2SPIKE_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (w_pop && w_head == '0 && drop_count != 8'hFF)
            drop_count <= drop_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_letter2spike.sv
// Directed bench for letter2spike: default instance plus two instances with
// short/saturating ramps, all driven by the same letter stream.
module tb_letter2spike;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  letter_in = 8'h00;
    logic        letter_valid = 1'b0;

    logic        letter_ready, spike, busy;
    logic [7:0]  neuron_id;
    logic [15:0] voltage;
    logic        rdy_f, spk_f, bsy_f, rdy_9, spk_9, bsy_9;
    logic [7:0]  id_f, id_9;
    logic [15:0] v_f, v_9;
`ifdef LETTER2SPIKE_DROP_CNT_EN
    logic [7:0]  drop_count, drop_f, drop_9;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    letter2spike dut (
        .clk(clk), .reset(reset), .letter_in(letter_in), .letter_valid(letter_valid),
        .letter_ready(letter_ready), .neuron_id(neuron_id), .voltage(voltage),
        .spike(spike), .busy(busy)
`ifdef LETTER2SPIKE_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    letter2spike #(.RAMP_STEP(16'hF000), .THRESHOLD(16'hF000)) dut_f (
        .clk(clk), .reset(reset), .letter_in(letter_in), .letter_valid(letter_valid),
        .letter_ready(rdy_f), .neuron_id(id_f), .voltage(v_f),
        .spike(spk_f), .busy(bsy_f)
`ifdef LETTER2SPIKE_DROP_CNT_EN
        , .drop_count(drop_f)
`endif
    );

    letter2spike #(.RAMP_STEP(16'h9000)) dut_9 (
        .clk(clk), .reset(reset), .letter_in(letter_in), .letter_valid(letter_valid),
        .letter_ready(rdy_9), .neuron_id(id_9), .voltage(v_9),
        .spike(spk_9), .busy(bsy_9)
`ifdef LETTER2SPIKE_DROP_CNT_EN
        , .drop_count(drop_9)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        letter_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push1(input logic [7:0] l);
        letter_in = l;
        letter_valid = 1'b1;
        tick();
        letter_valid = 1'b0;
    endtask

    // Advance until the next spike edge (bounded); returns the edge index and id.
    task automatic wait_spike(input string tag, output int at, output logic [7:0] id);
        int n = 0;
        do begin
            tick();
            n++;
        end while (spike !== 1'b1 && n < 200);
        chk({tag, "_seen"}, 32'(spike), 32'd1);
        at = cyc;
        id = neuron_id;
    endtask

    initial begin
        int e0, t0, t1, t2, nsp;
        logic [7:0] id0, id1, id2;

        // Reset state
        do_reset();
        chk("rst_id", 32'(neuron_id), 32'h0);
        chk("rst_v", 32'(voltage), 32'h0);
        chk("rst_spike", 32'(spike), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(letter_ready), 32'h1);

        // Single letter: ramp 0..61440 in 4096 steps, spike on E16 only
        push1(8'h41);
        chk("t1_busy_e0", 32'(busy), 32'h1);
        tick();
        chk("t1_id_e1", 32'(neuron_id), 32'h41);
        chk("t1_v_e1", 32'(voltage), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("t1_v_e%0d", k + 1), 32'(voltage), 32'(k * 4096));
            chk($sformatf("t1_spk_e%0d", k + 1), 32'(spike), (k == 15) ? 32'h1 : 32'h0);
        end
        tick();
        chk("t1_spk_e17", 32'(spike), 32'h0);
        chk("t1_v_e17", 32'(voltage), 32'h0);
        tick();
        chk("t1_busy_e18", 32'(busy), 32'h1);
        tick();
        chk("t1_busy_e19", 32'(busy), 32'h0);
        chk("t1_id_hold", 32'(neuron_id), 32'h41);

        // Back-to-back 41/42/43: spikes at E16, E35, E54
        do_reset();
        letter_valid = 1'b1;
        letter_in = 8'h41; tick();
        e0 = cyc;
        letter_in = 8'h42; tick();
        letter_in = 8'h43; tick();
        letter_valid = 1'b0;
        wait_spike("t2a", t0, id0);
        wait_spike("t2b", t1, id1);
        wait_spike("t2c", t2, id2);
        chk("t2_lat", 32'(t0 - e0), 32'd16);
        chk("t2_gap1", 32'(t1 - t0), 32'd19);
        chk("t2_gap2", 32'(t2 - t1), 32'd19);
        chk("t2_id0", 32'(id0), 32'h41);
        chk("t2_id1", 32'(id1), 32'h42);
        chk("t2_id2", 32'(id2), 32'h43);
        tick(); tick();
        chk("t2_busy_refr", 32'(busy), 32'h1);
        tick();
        chk("t2_busy_end", 32'(busy), 32'h0);

        // Five letters while busy: fifo fills, sixth refused, order kept
        do_reset();
        letter_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            letter_in = 8'h51 + 8'(i);
            chk($sformatf("t3_ready_%0d", i), 32'(letter_ready), 32'h1);
            tick();
        end
        chk("t3_full", 32'(letter_ready), 32'h0);
        letter_in = 8'h56;
        tick();
        chk("t3_full_hold", 32'(letter_ready), 32'h0);
        letter_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_spike($sformatf("t3_%0d", i), t0, id0);
            chk($sformatf("t3_id%0d", i), 32'(id0), 32'h51 + 32'(i));
        end
        nsp = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (spike === 1'b1) nsp++;
        end
        chk("t3_no_extra", 32'(nsp), 32'd0);
        chk("t3_idle", 32'(busy), 32'h0);

        // Letter 0 is discarded; 44 spikes at E17
        do_reset();
        letter_valid = 1'b1;
        letter_in = 8'h00; tick();
        e0 = cyc;
        letter_in = 8'h44; tick();
        letter_valid = 1'b0;
        chk("t4_id_after_drop", 32'(neuron_id), 32'h0);
        wait_spike("t4", t0, id0);
        chk("t4_lat", 32'(t0 - e0), 32'd17);
        chk("t4_id", 32'(id0), 32'h44);
`ifdef LETTER2SPIKE_DROP_CNT_EN
        chk("t4_drop", 32'(drop_count), 32'd1);
`endif

        // Reset mid-ramp at voltage 20480
        do_reset();
        push1(8'h41);
        for (int i = 0; i < 6; i++) tick();
        chk("t5_v_pre", 32'(voltage), 32'd20480);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_id", 32'(neuron_id), 32'h0);
        chk("t5_v", 32'(voltage), 32'h0);
        chk("t5_spk", 32'(spike), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_ready", 32'(letter_ready), 32'h1);
        nsp = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (spike === 1'b1) nsp++;
        end
        chk("t5_no_spike", 32'(nsp), 32'd0);
`ifdef LETTER2SPIKE_DROP_CNT_EN
        chk("t5_drop_clr", 32'(drop_count), 32'd0);
`endif

        // Alternate ramps: F000 step fires at E2, 9000 step saturates at E3
        do_reset();
        push1(8'h61);
        tick();
        chk("t6f_v_e1", 32'(v_f), 32'h0);
        chk("t6f_spk_e1", 32'(spk_f), 32'h0);
        tick();
        chk("t6f_spk_e2", 32'(spk_f), 32'h1);
        chk("t6f_v_e2", 32'(v_f), 32'hF000);
        chk("t6f_id", 32'(id_f), 32'h61);
        chk("t69_v_e2", 32'(v_9), 32'h9000);
        chk("t69_spk_e2", 32'(spk_9), 32'h0);
        tick();
        chk("t69_spk_e3", 32'(spk_9), 32'h1);
        chk("t69_v_e3", 32'(v_9), 32'hFFFF);
        chk("t6f_spk_e3", 32'(spk_f), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
